id_issue_ctrl: RTL

Decode-stage issue controller: owns the ID pipeline valid bit, the fetch→decode→execute valid/allowin handshake and a per-register scoreboard of in-flight writes. It stalls the instruction held in ID on read-after-write hazards (no forwarding), and kills it on a branch flush. It sits beside the ID decode logic: it consumes the register fields and write-enable the decoder produces, and it gates what ID hands to EX.

---
 rtl/id_issue_ctrl_pkg.sv | 25 ++
 rtl/id_issue_ctrl_if.sv | 36 +++
 rtl/id_issue_ctrl_sb_counter_bank.sv | 71 +++++++
 rtl/id_issue_ctrl.sv | 61 ++++++
 4 files changed

// File: rtl/id_issue_ctrl_pkg.sv
// Shared types and constants for the decode-stage issue controller and its
// in-flight write scoreboard.
package id_issue_ctrl_pkg;

    localparam int REG_NUM = 32;
    localparam int CNT_W   = 2;
    localparam int IDX_W   = $clog2(REG_NUM);

    typedef logic [IDX_W-1:0] reg_idx_t;
    typedef logic [CNT_W-1:0] sb_cnt_t;

    localparam sb_cnt_t CNT_MAX = '1;

    // Per-instruction view of the scoreboard, taken from registered counts.
    typedef struct packed {
        logic rs1_busy;
        logic rs2_busy;
        logic rd_full;
    } sb_query_t;

    function automatic logic is_tracked(reg_idx_t idx);
        return idx != '0;
    endfunction

endpackage

// File: rtl/id_issue_ctrl_if.sv
// IF/ID/EX handshake, decoded register fields, WB retire port and status
// flags of the issue controller.
interface id_issue_ctrl_if;
    import id_issue_ctrl_pkg::*;

    logic     fs_to_ds_valid;
    logic     ds_allowin;
    logic     es_allowin;
    logic     ds_to_es_valid;
    logic     ds_valid;
    reg_idx_t rs1;
    reg_idx_t rs2;
    logic     rs1_used;
    logic     rs2_used;
    reg_idx_t rd;
    logic     reg_write;
    logic     wb_we;
    reg_idx_t wb_rd;
    logic     br_flush;
    logic     stall_raw;
    logic     sb_busy;
    logic     sb_err;

    modport master (
        output fs_to_ds_valid, es_allowin, rs1, rs2, rs1_used, rs2_used,
               rd, reg_write, wb_we, wb_rd, br_flush,
        input  ds_allowin, ds_to_es_valid, ds_valid, stall_raw, sb_busy, sb_err
    );

    modport slave (
        input  fs_to_ds_valid, es_allowin, rs1, rs2, rs1_used, rs2_used,
               rd, reg_write, wb_we, wb_rd, br_flush,
        output ds_allowin, ds_to_es_valid, ds_valid, stall_raw, sb_busy, sb_err
    );

endinterface

// File: rtl/id_issue_ctrl_sb_counter_bank.sv
// Per-register in-flight write counters: incremented on issue, decremented
// on WB retire, with lookup ports for the ID instruction and a sticky error.
module sb_counter_bank
    import id_issue_ctrl_pkg::*;
(
    input  logic      clk,
    input  logic      resetn,
    input  logic      issue_we,
    input  reg_idx_t  issue_rd,
    input  logic      retire_we,
    input  reg_idx_t  retire_rd,
    input  reg_idx_t  rs1,
    input  reg_idx_t  rs2,
    input  reg_idx_t  rd,
    output sb_query_t query,
    output logic      busy,
    output logic      err
);

    sb_cnt_t [REG_NUM-1:0] cnt;
    sb_cnt_t [REG_NUM-1:0] cnt_next;
    logic    [REG_NUM-1:0] inc_vec;
    logic    [REG_NUM-1:0] dec_vec;
    logic                  err_set;

    // x0 never gets a bit set, so its counter stays at zero forever.
    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        if (issue_we && is_tracked(issue_rd)) begin
            inc_vec[issue_rd] = 1'b1;
        end
        if (retire_we && is_tracked(retire_rd)) begin
            dec_vec[retire_rd] = 1'b1;
        end
    end

    always_comb begin
        cnt_next = cnt;
        err_set  = 1'b0;
        for (int r = 0; r < REG_NUM; r++) begin
            case ({inc_vec[r], dec_vec[r]})
                2'b10: cnt_next[r] = cnt[r] + sb_cnt_t'(1);
                2'b01: begin
                    if (cnt[r] != '0) begin
                        cnt_next[r] = cnt[r] - sb_cnt_t'(1);
                    end else begin
                        err_set = 1'b1;
                    end
                end
                default: cnt_next[r] = cnt[r];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt <= '0;
            err <= 1'b0;
        end else begin
            cnt <= cnt_next;
            err <= err | err_set;
        end
    end

    assign query.rs1_busy = cnt[rs1] != '0;
    assign query.rs2_busy = cnt[rs2] != '0;
    assign query.rd_full  = cnt[rd] == CNT_MAX;
    assign busy           = |cnt;

endmodule

// File: rtl/id_issue_ctrl.sv
// Decode-stage issue controller: ID valid bit, IF->ID->EX handshake and
// read-after-write stalling against the in-flight write scoreboard.
module id_issue_ctrl
    import id_issue_ctrl_pkg::*;
(
    input logic           clk,
    input logic           resetn,
    id_issue_ctrl_if.slave bus
);

    logic      ds_valid;
    logic      hazard;
    logic      ds_ready_go;
    logic      ds_allowin;
    logic      ds_to_es_valid;
    logic      issue;
    sb_query_t query;

    sb_counter_bank u_sb (
        .clk       (clk),
        .resetn    (resetn),
        .issue_we  (issue && bus.reg_write),
        .issue_rd  (bus.rd),
        .retire_we (bus.wb_we),
        .retire_rd (bus.wb_rd),
        .rs1       (bus.rs1),
        .rs2       (bus.rs2),
        .rd        (bus.rd),
        .query     (query),
        .busy      (bus.sb_busy),
        .err       (bus.sb_err)
    );

    // The rd term stops an issue that would overflow the counter.
    always_comb begin
        hazard = (bus.rs1_used  && is_tracked(bus.rs1) && query.rs1_busy)
              || (bus.rs2_used  && is_tracked(bus.rs2) && query.rs2_busy)
              || (bus.reg_write && is_tracked(bus.rd)  && query.rd_full);
    end

    assign ds_ready_go    = !hazard;
    assign ds_allowin     = !ds_valid || (ds_ready_go && bus.es_allowin) || bus.br_flush;
    assign ds_to_es_valid = ds_valid && ds_ready_go && !bus.br_flush;
    assign issue          = ds_to_es_valid && bus.es_allowin;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ds_valid <= 1'b0;
        end else if (bus.br_flush) begin
            ds_valid <= 1'b0;
        end else if (ds_allowin) begin
            ds_valid <= bus.fs_to_ds_valid;
        end
    end

    assign bus.ds_valid       = ds_valid;
    assign bus.ds_allowin     = ds_allowin;
    assign bus.ds_to_es_valid = ds_to_es_valid;
    assign bus.stall_raw      = ds_valid && hazard && !bus.br_flush;

endmodule
